// File: rtl/ddr2_app_pkg.sv
// Constants, state encodings and helpers shared by the blocks on the DDR2 controller app port.
package ddr2_app_pkg;

  typedef enum logic [3:0] {
    S_WAIT_INIT = 4'd0,
    S_IDLE      = 4'd1,
    S_FILL      = 4'd2,
    S_CMD       = 4'd3,
    S_BEAT1     = 4'd4,
    S_DONE      = 4'd5
  } ddr2_state_e;

  localparam int unsigned DDR2_ADDR_W   = 31;
  localparam int unsigned DDR2_WDF_W    = 128;
  localparam int unsigned WORDS_PER_CMD = 8;
  localparam int unsigned BEATS_PER_CMD = 2;
  localparam logic [DDR2_ADDR_W-1:0] ADDR_STEP = 31'd4;

  // Next command address; wraps to 0 after the last legal address.
  function automatic logic [DDR2_ADDR_W-1:0] next_cmd_addr(
    input logic [DDR2_ADDR_W-1:0] cur,
    input logic [DDR2_ADDR_W-1:0] top
  );
    return (cur == top) ? '0 : cur + ADDR_STEP;
  endfunction

endpackage

// File: rtl/ddr2_word_packer.sv
// Collects 8 stream words into two 128-bit write beats (slot k at bits [32k+31:32k] of beat0:beat1).
module ddr2_word_packer
  import ddr2_app_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  fill_en,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  last_word,
  output logic [DDR2_WDF_W-1:0] beat0,
  output logic [DDR2_WDF_W-1:0] beat1
);

  localparam int unsigned WCNT_W = $clog2(WORDS_PER_CMD);

  logic [WCNT_W-1:0]                      wcnt_q, wcnt_d;
  logic [WORDS_PER_CMD*32-1:0]            buf_q, buf_d;
  logic                                   accept;

  assign in_ready  = fill_en;
  assign accept    = in_valid && fill_en;
  assign last_word = accept && (wcnt_q == WCNT_W'(WORDS_PER_CMD - 1));
  assign beat0     = buf_q[DDR2_WDF_W-1:0];
  assign beat1     = buf_q[2*DDR2_WDF_W-1:DDR2_WDF_W];

  // Store accepted word at the current slot; counter wraps naturally after slot 7.
  always_comb begin
    wcnt_d = wcnt_q;
    buf_d  = buf_q;
    if (accept) begin
      buf_d[32*wcnt_q +: 32] = in_data;
      wcnt_d                 = wcnt_q + WCNT_W'(1);
    end
  end

  // Slot counter; reset discards any partially filled buffer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) wcnt_q <= '0;
    else      wcnt_q <= wcnt_d;
  end

  // Data storage needs no reset: every slot is rewritten before it is read.
  always_ff @(posedge CLK) begin
    buf_q <= buf_d;
  end

endmodule

// File: rtl/ddr2_stream_writer.sv
// Streams 32-bit words into the DDR2 app interface as 8-word write commands.
module ddr2_stream_writer
  import ddr2_app_pkg::*;
#(
  parameter logic [30:0] ADDR_TOP = 31'h01FF_FFFC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              phy_init_done,
  output logic              app_af_wren,
  input  logic              app_af_afull,
  output logic [30:0]       app_af_addr,
  output logic              app_af_read,
  output logic              app_wdf_wren,
  input  logic              app_wdf_afull,
  output logic [127:0]      app_wdf_data,
  output logic [15:0]       app_wdf_mask_data,
  input  logic              start,
  input  logic [30:0]       base_addr,
  input  logic [CNT_W-1:0]  num_cmds,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cmds_done
);

  ddr2_state_e              state_q, state_d;
  logic [30:0]              cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]         remaining_q, remaining_d;
  logic [CNT_W-1:0]         cmds_done_q, cmds_done_d;
  logic                     af_wren_q, af_wren_d;
  logic [30:0]              af_addr_q, af_addr_d;
  logic                     wdf_wren_q, wdf_wren_d;
  logic [127:0]             wdf_data_q, wdf_data_d;
  logic                     done_q, done_d;
  logic                     last_word;
  logic [127:0]             beat0, beat1;

  ddr2_word_packer u_packer (
    .CLK       (CLK),
    .RST       (RST),
    .fill_en   (state_q == S_FILL),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .last_word (last_word),
    .beat0     (beat0),
    .beat1     (beat1)
  );

  assign busy              = (state_q != S_IDLE);
  assign app_af_wren       = af_wren_q;
  assign app_af_addr       = af_addr_q;
  assign app_af_read       = 1'b0;
  assign app_wdf_wren      = wdf_wren_q;
  assign app_wdf_data      = wdf_data_q;
  assign app_wdf_mask_data = '0;
  assign done              = done_q;
  assign cmds_done         = cmds_done_q;

  // Next-state and registered-output decode; strobes default low so each lasts one cycle.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    cmds_done_d = cmds_done_q;
    af_wren_d   = 1'b0;
    af_addr_d   = af_addr_q;
    wdf_wren_d  = 1'b0;
    wdf_data_d  = wdf_data_q;
    done_d      = 1'b0;
    case (state_q)
      S_WAIT_INIT: begin
        if (phy_init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (start) begin
          cur_addr_d  = {base_addr[30:2], 2'b00};
          remaining_d = num_cmds;
          cmds_done_d = '0;
          state_d     = (num_cmds == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (last_word) state_d = S_CMD;
      end
      S_CMD: begin
        // Address and beat0 go out together so data never separates from its command.
        if (!app_af_afull && !app_wdf_afull) begin
          af_wren_d  = 1'b1;
          af_addr_d  = cur_addr_q;
          wdf_wren_d = 1'b1;
          wdf_data_d = beat0;
          state_d    = S_BEAT1;
        end
      end
      S_BEAT1: begin
        if (!app_wdf_afull) begin
          wdf_wren_d  = 1'b1;
          wdf_data_d  = beat1;
          cmds_done_d = cmds_done_q + CNT_W'(1);
          cur_addr_d  = next_cmd_addr(cur_addr_q, ADDR_TOP);
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            remaining_d = remaining_q - CNT_W'(1);
            state_d     = S_FILL;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_WAIT_INIT;
    endcase
  end

  // All control state and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_WAIT_INIT;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      cmds_done_q <= '0;
      af_wren_q   <= 1'b0;
      af_addr_q   <= '0;
      wdf_wren_q  <= 1'b0;
      wdf_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      cmds_done_q <= cmds_done_d;
      af_wren_q   <= af_wren_d;
      af_addr_q   <= af_addr_d;
      wdf_wren_q  <= wdf_wren_d;
      wdf_data_q  <= wdf_data_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_ddr2_stream_writer.sv
// Scoreboard bench for ddr2_stream_writer.
module tb_ddr2_stream_writer;

  localparam logic [30:0] ADDR_TOP = 31'h01FF_FFFC;
  localparam int unsigned CNT_W    = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              phy_init_done = 1'b0;
  logic              app_af_wren;
  logic              app_af_afull = 1'b0;
  logic [30:0]       app_af_addr;
  logic              app_af_read;
  logic              app_wdf_wren;
  logic              app_wdf_afull = 1'b0;
  logic [127:0]      app_wdf_data;
  logic [15:0]       app_wdf_mask_data;
  logic              start = 1'b0;
  logic [30:0]       base_addr = '0;
  logic [CNT_W-1:0]  num_cmds = '0;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  cmds_done;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned af_cnt      = 0;
  int unsigned wdf_cnt     = 0;
  int unsigned done_cnt    = 0;
  logic        done_prev   = 1'b0;
  logic        mon_en      = 1'b0;

  logic [30:0]  af_q[$];
  logic [127:0] wdf_q[$];

  ddr2_stream_writer #(.ADDR_TOP(ADDR_TOP), .CNT_W(CNT_W)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .phy_init_done     (phy_init_done),
    .app_af_wren       (app_af_wren),
    .app_af_afull      (app_af_afull),
    .app_af_addr       (app_af_addr),
    .app_af_read       (app_af_read),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_afull     (app_wdf_afull),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask_data (app_wdf_mask_data),
    .start             (start),
    .base_addr         (base_addr),
    .num_cmds          (num_cmds),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .busy              (busy),
    .done              (done),
    .cmds_done         (cmds_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on each strobe.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (app_af_wren) begin
        af_cnt++;
        if (af_q.size() == 0) chk("af_unexpected", 1, 0);
        else                  chk("af_addr", app_af_addr, af_q.pop_front());
        chk("af_read", app_af_read, 0);
        chk("af_with_beat0", app_wdf_wren, 1);
      end
      if (app_wdf_wren) begin
        wdf_cnt++;
        if (wdf_q.size() == 0) chk("wdf_unexpected", 1, 0);
        else                   chk("wdf_data", app_wdf_data, wdf_q.pop_front());
        chk("wdf_mask", app_wdf_mask_data, 0);
      end
      if (done_prev) chk("busy_after_done", busy, 0);
      if (done) done_cnt++;
      done_prev = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [31:0] w);
    logic acc;
    int unsigned n;
    n        = 0;
    acc      = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge CLK);
      acc = in_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    if (!acc) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // stride 0 gives random words, otherwise first + k*stride.
  task automatic feed_cmd(input logic [31:0] first, input logic [31:0] stride);
    logic [31:0] w[8];
    for (int k = 0; k < 8; k++) begin
      w[k] = (stride == 0) ? $urandom : first + stride * k;
      push_word(w[k]);
    end
    wdf_q.push_back({w[3], w[2], w[1], w[0]});
    wdf_q.push_back({w[7], w[6], w[5], w[4]});
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (busy && n < 200);
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic do_start(input logic [30:0] base, input logic [CNT_W-1:0] n);
    @(posedge CLK);
    #1;
    base_addr = base;
    num_cmds  = n;
    start     = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned exp_pulses);
    int unsigned d0;
    int unsigned n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    repeat (4) @(negedge CLK);
    chk("done_pulses", done_cnt - d0, exp_pulses);
  endtask

  initial begin
    int unsigned a0;
    int unsigned w0;
    int unsigned d0;
    logic [30:0] top_m4;
    top_m4 = ADDR_TOP - 31'd4;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_af_wren", app_af_wren, 0);
    chk("rst_af_addr", app_af_addr, 0);
    chk("rst_wdf_wren", app_wdf_wren, 0);
    chk("rst_wdf_data", app_wdf_data, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_cmds_done", cmds_done, 0);
    @(posedge CLK); #1;
    RST    = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge CLK);
    chk("wait_init_busy", busy, 1);
    @(posedge CLK); #1;
    phy_init_done = 1'b1;
    wait_idle();

    // Single command from 0x100 with words 0..7
    af_q.push_back(31'h100);
    do_start(31'h100, 16'd1);
    feed_cmd(32'h0, 32'h1);
    wait_done(1);
    chk("t1_cmds_done", cmds_done, 1);
    chk("t1_beat0_literal", {32'h3, 32'h2, 32'h1, 32'h0}, 128'h00000003_00000002_00000001_00000000);

    // Init loss after calibration must be ignored
    phy_init_done = 1'b0;

    // Three commands, continuous stream, base with low bits set
    a0 = af_cnt; w0 = wdf_cnt;
    af_q.push_back(31'h0); af_q.push_back(31'h4); af_q.push_back(31'h8);
    do_start(31'h3, 16'd3);
    for (int c = 0; c < 3; c++) feed_cmd(32'h0, 32'h0);
    wait_done(1);
    chk("t2_cmds_done", cmds_done, 3);
    chk("t2_af_count", af_cnt - a0, 3);
    chk("t2_wdf_count", wdf_cnt - w0, 6);

    // Backpressure on both FIFOs
    a0 = af_cnt; w0 = wdf_cnt;
    af_q.push_back(31'h200);
    app_af_afull = 1'b1;
    do_start(31'h200, 16'd1);
    feed_cmd(32'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("afull_af_wren", app_af_wren, 0);
      chk("afull_wdf_wren", app_wdf_wren, 0);
      chk("afull_in_ready", in_ready, 0);
    end
    app_af_afull = 1'b0;
    @(posedge CLK); #1;
    app_wdf_afull = 1'b1;
    @(negedge CLK);
    chk("beat0_after_release", app_af_wren, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("wfull_wdf_wren", app_wdf_wren, 0);
      chk("wfull_af_wren", app_af_wren, 0);
      chk("wfull_in_ready", in_ready, 0);
    end
    @(posedge CLK); #1;
    app_wdf_afull = 1'b0;
    wait_done(1);
    chk("bp_af_count", af_cnt - a0, 1);
    chk("bp_wdf_count", wdf_cnt - w0, 2);

    // Address wrap at ADDR_TOP
    af_q.push_back(top_m4); af_q.push_back(ADDR_TOP); af_q.push_back(31'h0);
    do_start(top_m4, 16'd3);
    for (int c = 0; c < 3; c++) feed_cmd(32'h0, 32'h0);
    wait_done(1);
    chk("wrap_cmds_done", cmds_done, 3);

    // Zero-length transfer
    a0 = af_cnt; w0 = wdf_cnt; d0 = done_cnt;
    do_start(31'h600, 16'd0);
    @(negedge CLK);
    chk("zero_done_c1", done, 0);
    @(negedge CLK);
    chk("zero_done_c2", done, 1);
    chk("zero_cmds_done", cmds_done, 0);
    repeat (3) @(negedge CLK);
    chk("zero_done_pulses", done_cnt - d0, 1);
    chk("zero_no_af", af_cnt - a0, 0);
    chk("zero_no_wdf", wdf_cnt - w0, 0);

    // Start during busy transfer is ignored
    af_q.push_back(31'h300);
    do_start(31'h300, 16'd1);
    push_word(32'hA0); push_word(32'hA1); push_word(32'hA2);
    do_start(31'h700, 16'd5);
    push_word(32'hA3); push_word(32'hA4); push_word(32'hA5);
    push_word(32'hA6); push_word(32'hA7);
    wdf_q.push_back(128'h000000A3_000000A2_000000A1_000000A0);
    wdf_q.push_back(128'h000000A7_000000A6_000000A5_000000A4);
    wait_done(1);
    chk("ignored_start_cmds_done", cmds_done, 1);
    repeat (3) @(negedge CLK);
    chk("ignored_start_idle", busy, 0);

    // Reset after word 5 of command 2
    af_q.push_back(31'h400);
    do_start(31'h400, 16'd3);
    feed_cmd(32'h0, 32'h0);
    for (int k = 0; k < 6; k++) push_word(32'hDEAD_0000 + k);
    phy_init_done = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_af_wren", app_af_wren, 0);
    chk("mid_rst_af_addr", app_af_addr, 0);
    chk("mid_rst_wdf_wren", app_wdf_wren, 0);
    chk("mid_rst_wdf_data", app_wdf_data, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cmds_done", cmds_done, 0);
    chk("mid_rst_busy", busy, 1);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_wait_init", busy, 1);
    chk("post_rst_in_ready", in_ready, 0);
    @(posedge CLK); #1;
    phy_init_done = 1'b1;
    wait_idle();
    af_q.push_back(31'h500);
    do_start(31'h500, 16'd1);
    feed_cmd(32'h5500_0000, 32'h1);
    wait_done(1);
    chk("post_rst_cmds_done", cmds_done, 1);

    chk("af_queue_drained", af_q.size(), 0);
    chk("wdf_queue_drained", wdf_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr2_stream_writer.md
Name: ddr2_stream_writer

Overview:
- Streams 32-bit words from an upstream producer into the DDR2 controller application interface (address FIFO plus write-data FIFO).
- Packs 8 words into one write command: one address entry followed by two 128-bit data beats.
- Sits on the same controller app port as the DDR2 self-test block, upstream of the controller.
- Provides start/busy/done control for capturing a contiguous region of DDR2.

Parameters:
- ADDR_TOP, 31'h01FF_FFFC, last legal command address; the address following ADDR_TOP is 0.
- CNT_W, 16, width of the command-count input and output.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- phy_init_done  in  1  controller calibration complete
- app_af_wren  out  1  address FIFO write strobe
- app_af_afull  in  1  address FIFO almost full
- app_af_addr  out  31  command address
- app_af_read  out  1  command type; always 0 (write)
- app_wdf_wren  out  1  write-data FIFO strobe
- app_wdf_afull  in  1  write-data FIFO almost full
- app_wdf_data  out  128  write-data beat
- app_wdf_mask_data  out  16  byte mask; constant 16'h0000
- start  in  1  one-cycle start pulse
- base_addr  in  31  first command address; bits [1:0] are ignored and forced to 0
- num_cmds  in  CNT_W  number of 8-word commands to issue
- in_data  in  32  stream word
- in_valid  in  1  stream word valid
- in_ready  out  1  stream word accepted when in_valid && in_ready
- busy  out  1  high in every state except S_IDLE
- done  out  1  one-cycle pulse at transfer end
- cmds_done  out  CNT_W  commands issued in the current or last transfer

Behaviour:
- Reset values: app_af_wren=0, app_af_addr=0, app_af_read=0, app_wdf_wren=0, app_wdf_data=0, in_ready=0, done=0, cmds_done=0, state=S_WAIT_INIT, word count=0.
- All outputs are registered, except busy and in_ready, which are decoded from state.
- States:
  - S_WAIT_INIT -> S_IDLE when phy_init_done=1.
  - S_IDLE:
    - start=1 captures {base_addr[30:2],2'b00} into cur_addr and num_cmds into remaining, and clears cmds_done.
    - If num_cmds=0 -> S_DONE, else -> S_FILL.
    - start is ignored in every state other than S_IDLE.
  - S_FILL:
    - in_ready=1.
    - Each accepted word is stored at slot wcnt, and wcnt increments.
    - Slot k occupies bits [32*(k%4)+31 : 32*(k%4)] of beat k/4.
    - Acceptance of slot 7 -> S_CMD, and wcnt wraps to 0.
  - S_CMD:
    - in_ready=0.
    - When app_af_afull=0 and app_wdf_afull=0 in a cycle, the next cycle presents app_af_wren=1, app_af_addr=cur_addr, app_wdf_wren=1, app_wdf_data=beat0. State -> S_BEAT1.
    - Otherwise the block holds with both strobes 0.
  - S_BEAT1:
    - app_af_wren returns to 0 in the next cycle.
    - When app_wdf_afull=0 in a cycle, the next cycle presents app_wdf_wren=1, app_wdf_data=beat1. In the same update, cmds_done+1 and cur_addr advances (see address rule).
    - If remaining=1 -> S_DONE, else remaining-1 -> S_FILL.
    - While app_wdf_afull=1, app_wdf_wren=0 and the block holds.
  - S_DONE: done=1 for exactly one cycle -> S_IDLE.
- Strobes are single-cycle. Between beat1 and the next beat0 there is at least one fill cycle, so minimum command spacing is 8 fill cycles + 2.
- Address rule: cur_addr += 4 per command. If cur_addr==ADDR_TOP the next address is 0. Arithmetic is 31-bit.
- Data beats are never split from their address: beat0 is always written in the same cycle as its address entry.
- Latency: from acceptance of word 7 with both FIFOs non-full, app_af_wren rises 2 cycles later.
- phy_init_done falling after S_WAIT_INIT has no effect.
- Reset mid-transfer:
  - All state clears immediately, and the partially filled buffer is discarded.
  - No strobe may be asserted in the cycle after RST falls.
- No data is dropped: in_ready is low whenever the buffer is full.

Decomposition:
- Shared package ddr2_app_pkg:
  - state encodings S_WAIT_INIT..S_DONE (4-bit)
  - ADDR_STEP=31'd4
  - WORDS_PER_CMD=8
  - BEATS_PER_CMD=2
  - DDR2_WDF_W=128
  - DDR2_ADDR_W=31
  - The self-test block and this block share these constants.
- Sub-module ddr2_word_packer: holds the 8x32 buffer, wcnt, in_ready gating and beat0/beat1 outputs. The FSM and FIFO handshake stay in the top.

Test Plan:
- Reset + phy_init_done high after 10 cycles; start with base 0x100, num_cmds=1; feed words 0x0..0x7 -> expected outcome:
  - one af write at addr 0x100, read=0
  - beat0=0x00000003_00000002_00000001_00000000 and beat1=0x00000007_..._00000004
  - done pulses once, cmds_done=1
- num_cmds=3 from base 0, continuous in_valid -> af addrs 0x0, 0x4, 0x8; 6 wdf beats in word order; busy drops the cycle after done.
- Hold app_af_afull=1 for 20 cycles in S_CMD, then app_wdf_afull=1 for 5 cycles in S_BEAT1 -> expected outcome:
  - no strobes while asserted
  - in_ready=0 throughout
  - a single af/wdf strobe after release
  - beat order preserved
- base=ADDR_TOP-4, num_cmds=3 -> addrs ADDR_TOP-4, ADDR_TOP, 0x0.
- num_cmds=0 -> done pulses 2 cycles after start, no strobes, cmds_done=0. A start pulse during a busy transfer is ignored.
- Assert RST low after word 5 of command 2 -> all outputs return to reset values, state goes to S_WAIT_INIT, and a new start after init begins at slot 0.
